// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the parametrised convolution controller.
// Optional build macro used by the top: CTRL_PERF_CNT_EN (stall cycle counter).
package conv_ctrl_pkg;

    // Controller states; the encoding is also exported on the debug state port.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_K  = 3'd1,
        S_LOAD_I  = 3'd2,
        S_I_SHIFT = 3'd3,
        S_COMPUTE = 3'd4,
        S_DRAIN   = 3'd5
    } fsm_state;

    // ODS destination code meaning "nothing to route".
    localparam logic [1:0] ODS_SEL_IDLE = 2'b11;
    // ODS destination code for the result lanes driven onto the shared bus.
    localparam logic [1:0] ODS_SEL_OUT  = 2'b00;

    // Index width for a counter covering 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// Nested tile loop counter: x innermost, then y, then ch_out in steps of STEP.
// Each counter wraps to 0 after its last value; y and ch_out move only on x wrap.
module conv_loop_counter #(
    parameter int WIDTH  = 1024,
    parameter int HEIGHT = 1024,
    parameter int NB_CH  = 64,
    parameter int STEP   = 6
) (
    input  logic        clk,
    input  logic        arst_n_in,
    input  logic        inc,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] ch,
    output logic        last_x,
    output logic        last_y,
    output logic        last_ch
);

    localparam logic [31:0] X_LAST  = 32'(WIDTH - 1);
    localparam logic [31:0] Y_LAST  = 32'(HEIGHT - 1);
    localparam logic [31:0] CH_STEP = 32'(STEP);
    localparam logic [31:0] CH_END  = 32'(NB_CH);

    assign last_x  = (x == X_LAST);
    assign last_y  = (y == Y_LAST);
    // Treat the pass as final once another step would reach the channel count.
    assign last_ch = ((ch + CH_STEP) >= CH_END);

    // Advance the nested loop by one pixel on inc.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            x  <= '0;
            y  <= '0;
            ch <= '0;
        end else if (inc) begin
            if (last_x) begin
                x <= '0;
                if (last_y) begin
                    y  <= '0;
                    ch <= last_ch ? '0 : ch + CH_STEP;
                end else begin
                    y <= y + 32'd1;
                end
            end else begin
                x <= x + 32'd1;
            end
        end
    end

endmodule

// File: rtl/conv_ctrl_fsm_param.sv
// Parametrised convolution controller: kernel load, input row load, compute and
// output drain over a tiled x/y/ch_out loop.
// Optional build macro: CTRL_PERF_CNT_EN adds the stall_cycles counter port.
//
// Handshakes: a host beat happens on a cycle where con_valid && con_ready; an
// output beat happens on a cycle where output_valid && output_ready. A raised
// valid/coordinate set is held unchanged until its beat, and con_ready is kept
// low while an output beat is pending.
module conv_ctrl_fsm_param
    import conv_ctrl_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3,
    parameter int PAR_OUT            = 6,
    parameter int OUT_LANES          = 3,
    parameter int K_WORDS            = 12,
    parameter int K_GROUPS           = 6,
    parameter int I_WORDS            = 4
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    output logic                          running,
    output logic                          done,
    input  logic                          con_valid,
    output logic                          con_ready,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [31:0]                   output_x,
    output logic [31:0]                   output_y,
    output logic [31:0]                   output_ch,
    output logic                          ctrl_IDSS_shift,
    output logic [idx_w(I_WORDS)-1:0]     ctrl_IDSS_LE_select,
    output logic [K_WORDS-1:0]            ctrl_KDS_LE_select,
    output logic                          ctrl_to_KDS_cycle_enable,
    output logic                          ctrl_ODS_shift,
    output logic [1:0]                    ctrl_ODS_sel_out,
    output logic                          driving_cons,
    output logic [2:0]                    dbg_state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                   stall_cycles
`endif
);

    localparam int NB     = PAR_OUT / OUT_LANES;
    localparam int KW_W   = idx_w(K_WORDS);
    localparam int IW_W   = idx_w(I_WORDS);
    localparam int BEAT_W = $clog2(NB + 1);
    localparam int GRP_W  = idx_w(K_GROUPS);
    localparam int ROW_W  = idx_w(KERNEL_SIZE);

    localparam logic [KW_W-1:0]   K_LAST   = KW_W'(K_WORDS - 1);
    localparam logic [IW_W-1:0]   I_LAST   = IW_W'(I_WORDS - 1);
    localparam logic [GRP_W-1:0]  G_LAST   = GRP_W'(K_GROUPS - 1);
    localparam logic [ROW_W-1:0]  R_LAST   = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [BEAT_W-1:0] NB_LAST  = BEAT_W'(NB - 1);
    localparam logic [31:0]       LANES32  = 32'(OUT_LANES);

    fsm_state          state_q, state_d;
    logic [KW_W-1:0]   kw_q, kw_d;        // kernel word index
    logic [IW_W-1:0]   iw_q, iw_d;        // input word index / compute cycle
    logic [GRP_W-1:0]  g_q, g_d;          // kernel group index
    logic [ROW_W-1:0]  r_q, r_d;          // input row load index
    logic [BEAT_W-1:0] beat_q, beat_d;    // output beat index
    logic              pend_q, pend_d;    // a computed pixel awaits output
    logic              end_y_q, end_y_d;  // row being drained was the last row
    logic              end_ch_q, end_ch_d;// pass being drained was the last pass
    logic              done_q, done_d;
    logic              ovalid_q, ovalid_d;
    logic [31:0]       out_x_q, out_x_d;
    logic [31:0]       out_y_q, out_y_d;
    logic [31:0]       out_ch_q, out_ch_d;

    logic              lc_inc;
    logic [31:0]       lc_x, lc_y, lc_ch;
    logic              lc_last_x, lc_last_y, lc_last_ch;
    logic              comp_adv;          // COMPUTE makes progress this cycle
    logic              comp_final;        // current COMPUTE cycle closes the pixel

    conv_loop_counter #(
        .WIDTH  (FEATURE_MAP_WIDTH),
        .HEIGHT (FEATURE_MAP_HEIGHT),
        .NB_CH  (OUTPUT_NB_CHANNELS),
        .STEP   (PAR_OUT)
    ) u_loop (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .inc       (lc_inc),
        .x         (lc_x),
        .y         (lc_y),
        .ch        (lc_ch),
        .last_x    (lc_last_x),
        .last_y    (lc_last_y),
        .last_ch   (lc_last_ch)
    );

    // COMPUTE progress: cycle 0 waits for a host beat, result beats wait for output_ready.
    always_comb begin
        comp_adv   = 1'b0;
        comp_final = 1'b0;
        if (state_q == S_COMPUTE) begin
            if (ovalid_q) begin
                comp_adv   = output_ready;
                comp_final = (beat_q == NB_LAST);
            end else begin
                comp_adv   = (iw_q != '0) || con_valid;
                comp_final = (iw_q == I_LAST) && !pend_q;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q  <= S_IDLE;
            kw_q     <= '0;
            iw_q     <= '0;
            g_q      <= '0;
            r_q      <= '0;
            beat_q   <= '0;
            pend_q   <= 1'b0;
            end_y_q  <= 1'b0;
            end_ch_q <= 1'b0;
            done_q   <= 1'b0;
            ovalid_q <= 1'b0;
            out_x_q  <= '0;
            out_y_q  <= '0;
            out_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            kw_q     <= kw_d;
            iw_q     <= iw_d;
            g_q      <= g_d;
            r_q      <= r_d;
            beat_q   <= beat_d;
            pend_q   <= pend_d;
            end_y_q  <= end_y_d;
            end_ch_q <= end_ch_d;
            done_q   <= done_d;
            ovalid_q <= ovalid_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
            out_ch_q <= out_ch_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d  = state_q;
        kw_d     = kw_q;
        iw_d     = iw_q;
        g_d      = g_q;
        r_d      = r_q;
        beat_d   = beat_q;
        pend_d   = pend_q;
        end_y_d  = end_y_q;
        end_ch_d = end_ch_q;
        done_d   = 1'b0;
        ovalid_d = ovalid_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        out_ch_d = out_ch_q;
        lc_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_K;
                    kw_d    = '0;
                    iw_d    = '0;
                    g_d     = '0;
                    r_d     = '0;
                    beat_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            S_LOAD_K: begin
                if (con_valid) begin
                    if (kw_q == K_LAST) begin
                        kw_d = '0;
                        if (g_q == G_LAST) begin
                            g_d     = '0;
                            r_d     = '0;
                            iw_d    = '0;
                            state_d = S_LOAD_I;
                        end else begin
                            g_d = g_q + 1'b1;
                        end
                    end else begin
                        kw_d = kw_q + 1'b1;
                    end
                end
            end
            S_LOAD_I: begin
                if (con_valid) begin
                    if (iw_q == I_LAST) begin
                        iw_d    = '0;
                        state_d = S_I_SHIFT;
                    end else begin
                        iw_d = iw_q + 1'b1;
                    end
                end
            end
            S_I_SHIFT: begin
                if (r_q == R_LAST) begin
                    r_d     = '0;
                    iw_d    = '0;
                    state_d = S_COMPUTE;
                end else begin
                    r_d     = r_q + 1'b1;
                    state_d = S_LOAD_I;
                end
            end
            S_COMPUTE: begin
                if (comp_adv) begin
                    if (comp_final) begin
                        // Pixel complete: its coordinates become the pending results.
                        lc_inc   = 1'b1;
                        pend_d   = 1'b1;
                        iw_d     = '0;
                        beat_d   = '0;
                        out_x_d  = lc_x;
                        out_y_d  = lc_y;
                        out_ch_d = lc_ch;
                        if (lc_last_x) begin
                            end_y_d  = lc_last_y;
                            end_ch_d = lc_last_ch;
                            ovalid_d = 1'b1;
                            state_d  = S_DRAIN;
                        end else begin
                            ovalid_d = 1'b0;
                        end
                    end else if (ovalid_q) begin
                        beat_d   = beat_q + 1'b1;
                        out_ch_d = out_ch_q + LANES32;
                    end else if (iw_q == I_LAST) begin
                        // Input cycles done; present the previous pixel's results.
                        iw_d     = '0;
                        beat_d   = '0;
                        ovalid_d = 1'b1;
                    end else begin
                        iw_d = iw_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (output_ready) begin
                    if (beat_q == NB_LAST) begin
                        beat_d   = '0;
                        pend_d   = 1'b0;
                        ovalid_d = 1'b0;
                        kw_d     = '0;
                        iw_d     = '0;
                        g_d      = '0;
                        r_d      = '0;
                        if (!end_y_q) begin
                            state_d = S_LOAD_I;
                        end else if (!end_ch_q) begin
                            state_d = S_LOAD_K;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        beat_d   = beat_q + 1'b1;
                        out_ch_d = out_ch_q + LANES32;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath control outputs decoded from the current state.
    always_comb begin
        running                  = (state_q != S_IDLE);
        done                     = done_q;
        output_valid             = ovalid_q;
        output_x                 = out_x_q;
        output_y                 = out_y_q;
        output_ch                = out_ch_q;
        dbg_state                = state_q;
        con_ready                = 1'b0;
        ctrl_IDSS_shift          = 1'b0;
        ctrl_IDSS_LE_select      = '0;
        ctrl_KDS_LE_select       = '0;
        ctrl_to_KDS_cycle_enable = 1'b0;
        ctrl_ODS_shift           = 1'b0;
        ctrl_ODS_sel_out         = ODS_SEL_IDLE;
        driving_cons             = 1'b0;
        case (state_q)
            S_LOAD_K: begin
                con_ready = 1'b1;
                if (con_valid) ctrl_KDS_LE_select = K_WORDS'(1) << kw_q;
            end
            S_LOAD_I: begin
                con_ready           = 1'b1;
                ctrl_IDSS_LE_select = iw_q;
            end
            S_I_SHIFT: begin
                ctrl_IDSS_shift = 1'b1;
            end
            S_COMPUTE: begin
                con_ready                = !ovalid_q && (iw_q == '0);
                ctrl_to_KDS_cycle_enable = comp_adv;
                ctrl_IDSS_shift          = comp_adv && comp_final;
                if (ovalid_q) begin
                    ctrl_ODS_sel_out = ODS_SEL_OUT;
                    ctrl_ODS_shift   = output_ready;
                    driving_cons     = 1'b1;
                end
            end
            S_DRAIN: begin
                ctrl_ODS_sel_out = ODS_SEL_OUT;
                ctrl_ODS_shift   = output_ready;
                driving_cons     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic stall_evt;
    assign stall_evt = (ovalid_q && !output_ready) || (con_ready && !con_valid);

    // Saturating count of cycles lost to either side of the handshakes.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            stall_cycles <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_cycles <= '0;
        end else if (stall_evt && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_ctrl_fsm_param.sv
// Directed bench for conv_ctrl_fsm_param with a 2x2 map and 12 output channels.
module tb_conv_ctrl_fsm_param;
  import conv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n_in = 1'b0;
  logic        start = 1'b0;
  logic        con_valid = 1'b0;
  logic        output_ready = 1'b0;
  logic        running, done, con_ready, output_valid;
  logic [31:0] output_x, output_y, output_ch;
  logic        ctrl_IDSS_shift;
  logic [1:0]  ctrl_IDSS_LE_select;
  logic [11:0] ctrl_KDS_LE_select;
  logic        ctrl_to_KDS_cycle_enable, ctrl_ODS_shift;
  logic [1:0]  ctrl_ODS_sel_out;
  logic        driving_cons;
  logic [2:0]  dbg_state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  conv_ctrl_fsm_param #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(12),
    .KERNEL_SIZE(3), .PAR_OUT(6), .OUT_LANES(3), .K_WORDS(12), .K_GROUPS(6), .I_WORDS(4)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running), .done(done),
    .con_valid(con_valid), .con_ready(con_ready), .output_valid(output_valid),
    .output_ready(output_ready), .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .ctrl_IDSS_shift(ctrl_IDSS_shift), .ctrl_IDSS_LE_select(ctrl_IDSS_LE_select),
    .ctrl_KDS_LE_select(ctrl_KDS_LE_select), .ctrl_to_KDS_cycle_enable(ctrl_to_KDS_cycle_enable),
    .ctrl_ODS_shift(ctrl_ODS_shift), .ctrl_ODS_sel_out(ctrl_ODS_sel_out),
    .driving_cons(driving_cons), .dbg_state(dbg_state)
`ifdef CTRL_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic start_i, con_valid_i, output_ready_i;
    logic exp_running, exp_con_ready, exp_valid, exp_done;
    logic [1:0] exp_sel;
    logic [11:0] exp_le;
  } rst_vec_t;

  typedef struct {
    int stall;
    logic [31:0] x, y, ch;
    fsm_state st;
  } beat_vec_t;

  rst_vec_t  rvec[4];
  beat_vec_t bvec[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!output_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_output_valid", 32'(output_valid), 32'd1);
  endtask

  function automatic beat_vec_t mk(input int stall, input int x, input int y, input int ch, input fsm_state st);
    beat_vec_t b;
    b.stall = stall; b.x = 32'(x); b.y = 32'(y); b.ch = 32'(ch); b.st = st;
    return b;
  endfunction

  initial begin
    logic [11:0] exp_le;
    int n;

    // inputs in reset must not leak to the outputs
    rvec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 12'h000};
    rvec[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 12'h000};
    rvec[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 12'h000};
    rvec[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 12'h000};

    // expected result beats of a full run (x, y, ch, state while presented)
    bvec[0]  = mk(4, 0, 0, 0, S_COMPUTE); bvec[1]  = mk(0, 0, 0, 3, S_COMPUTE);
    bvec[2]  = mk(0, 1, 0, 0, S_DRAIN);   bvec[3]  = mk(0, 1, 0, 3, S_DRAIN);
    bvec[4]  = mk(0, 0, 1, 0, S_COMPUTE); bvec[5]  = mk(0, 0, 1, 3, S_COMPUTE);
    bvec[6]  = mk(0, 1, 1, 0, S_DRAIN);   bvec[7]  = mk(0, 1, 1, 3, S_DRAIN);
    bvec[8]  = mk(0, 0, 0, 6, S_COMPUTE); bvec[9]  = mk(0, 0, 0, 9, S_COMPUTE);
    bvec[10] = mk(0, 1, 0, 6, S_DRAIN);   bvec[11] = mk(0, 1, 0, 9, S_DRAIN);
    bvec[12] = mk(0, 0, 1, 6, S_COMPUTE); bvec[13] = mk(0, 0, 1, 9, S_COMPUTE);
    bvec[14] = mk(0, 1, 1, 6, S_DRAIN);   bvec[15] = mk(0, 1, 1, 9, S_DRAIN);

    // reset vectors
    for (int i = 0; i < 4; i++) begin
      start = rvec[i].start_i; con_valid = rvec[i].con_valid_i; output_ready = rvec[i].output_ready_i;
      @(negedge clk);
      chk("rst_running",   32'(running),            32'(rvec[i].exp_running));
      chk("rst_con_ready", 32'(con_ready),          32'(rvec[i].exp_con_ready));
      chk("rst_valid",     32'(output_valid),       32'(rvec[i].exp_valid));
      chk("rst_done",      32'(done),               32'(rvec[i].exp_done));
      chk("rst_ods_sel",   32'(ctrl_ODS_sel_out),   32'(rvec[i].exp_sel));
      chk("rst_kds_le",    32'(ctrl_KDS_LE_select), 32'(rvec[i].exp_le));
    end
    start = 1'b0; con_valid = 1'b0; output_ready = 1'b1;
    arst_n_in = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(dbg_state), 32'(S_IDLE));

    // run 1: full run, first result beat stalled for 4 cycles
    con_valid = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("run1_enter_load_k", 32'(dbg_state), 32'(S_LOAD_K));
    for (int i = 0; i < 16; i++) begin
      wait_valid(400);
      if (bvec[i].stall > 0) begin
        output_ready = 1'b0;
        for (int s = 0; s < bvec[i].stall; s++) begin
          @(posedge clk); @(negedge clk);
          chk("stall_valid",     32'(output_valid), 32'd1);
          chk("stall_x",         output_x,          bvec[i].x);
          chk("stall_y",         output_y,          bvec[i].y);
          chk("stall_ch",        output_ch,         bvec[i].ch);
          chk("stall_con_ready", 32'(con_ready),    32'd0);
          chk("stall_state",     32'(dbg_state),    32'(bvec[i].st));
        end
        output_ready = 1'b1;
      end
      chk("beat_x",     output_x,       bvec[i].x);
      chk("beat_y",     output_y,       bvec[i].y);
      chk("beat_ch",    output_ch,      bvec[i].ch);
      chk("beat_state", 32'(dbg_state), 32'(bvec[i].st));
      chk("beat_con_ready", 32'(con_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      if (i == 3) chk("after_drain_load_i", 32'(dbg_state), 32'(S_LOAD_I));
    end
    chk("run1_end_idle",    32'(dbg_state), 32'(S_IDLE));
    chk("run1_end_running", 32'(running),   32'd0);
    chk("run1_done_pulse",  32'(done),      32'd1);
    repeat (4) @(negedge clk);
    chk("run1_done_once",   32'(done_cnt),  32'd1);
    chk("run1_done_low",    32'(done),      32'd0);
`ifdef CTRL_PERF_CNT_EN
    chk("run1_stall_cycles", stall_cycles, 32'd4);
`endif

    // run 2: gap in kernel words at word 5, then reset in the middle of COMPUTE
    start = 1'b1; con_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
`ifdef CTRL_PERF_CNT_EN
    chk("run2_stall_cleared", stall_cycles, 32'd0);
`endif
    for (int k = 0; k < 12; k++) begin
      if (k == 5) begin
        con_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
          #1;
          chk("kds_le_gap", 32'(ctrl_KDS_LE_select), 32'd0);
          @(posedge clk); @(negedge clk);
        end
        con_valid = 1'b1;
      end
      #1;
      exp_le = 12'd1 << k;
      chk("kds_le_word", 32'(ctrl_KDS_LE_select), 32'(exp_le));
      @(posedge clk); @(negedge clk);
    end
    chk("kds_group1_first", 32'(ctrl_KDS_LE_select), 32'h001);
    n = 0;
    while (!(dbg_state == S_COMPUTE && output_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("run2_reach_compute_out", 32'(output_valid), 32'd1);
`ifdef CTRL_PERF_CNT_EN
    chk("run2_stall_cycles", stall_cycles, 32'd3);
`endif
    arst_n_in = 1'b0;
    #1;
    chk("arst_state",   32'(dbg_state),        32'(S_IDLE));
    chk("arst_running", 32'(running),          32'd0);
    chk("arst_valid",   32'(output_valid),     32'd0);
    chk("arst_ods_sel", 32'(ctrl_ODS_sel_out), 32'h3);
    chk("arst_x",       output_x,              32'd0);
    @(negedge clk);
    arst_n_in = 1'b1; con_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_arst_idle",      32'(dbg_state), 32'(S_IDLE));
    chk("post_arst_con_ready", 32'(con_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
